// File: rtl/oam_dma_pkg.sv
// Shared definitions for the sprite DMA engine.
// Holds the FSM state encoding, the bus read/write polarity constants,
// the default trigger/destination addresses and the helper that decides
// whether a transfer needs an alignment cycle before its first read.
package oam_dma_pkg;

  // FSM state encoding (3 bits)
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_t;

  // Bus read/write polarity: read is high, write is low
  localparam logic RW_R = 1'b1;
  localparam logic RW_W = 1'b0;

  // Default addresses
  localparam logic [15:0] DEF_TRIG_ADDR = 16'h4014;
  localparam logic [15:0] DEF_OAM_ADDR  = 16'h2004;

  // Leaving HALT: reads must start on an even cycle. The argument is the
  // parity of the current (HALT) cycle, so the following cycle is even
  // exactly when the current one is odd.
  function automatic dma_state_t halt_exit(input logic cur_parity);
    dma_state_t nxt;
    if (cur_parity == 1'b1) begin
      nxt = ST_READ;
    end else begin
      nxt = ST_ALIGN;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine sitting between the CPU core and the system bus mux.
// A CPU write to TRIG_ADDR halts the core, then the engine copies the 256
// bytes of page {cpu_d,8'h00} to the OAM data port (OAM_ADDR) as
// alternating read/write cycles, and finally hands the bus back.
//
// Ports:
//   clk        system clock, one CPU cycle per rising edge
//   rst_n      asynchronous active-low reset
//   cpu_a      core address output (snooped for the trigger)
//   cpu_d      core write data; the trigger byte is the source page
//   cpu_rw     core read/write (1 = read, 0 = write)
//   bus_d_in   read data returned from the bus
//   cpu_halt   stall request to the core
//   bus_sel    1 = bus mux takes the DMA address/data/rw, 0 = core
//   bus_a      DMA address
//   bus_d_out  DMA write data
//   bus_rw     DMA read/write
//   dma_busy   transfer in progress (status)
//
// All outputs are registered: the next-cycle values are computed from the
// next state and loaded on the same edge as the state itself.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] TRIG_ADDR = DEF_TRIG_ADDR,
  parameter logic [15:0] OAM_ADDR  = DEF_OAM_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_d_in,
  output logic        cpu_halt,
  output logic        bus_sel,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_d_out,
  output logic        bus_rw,
  output logic        dma_busy
);

  dma_state_t  state_r;
  dma_state_t  state_nx_s;
  logic        parity_r;
  logic [7:0]  index_r;
  logic [7:0]  index_nx_s;
  logic [7:0]  page_r;
  logic [7:0]  page_nx_s;
  logic [7:0]  latch_r;
  logic [7:0]  latch_nx_s;

  logic        busy_r;
  logic [15:0] bus_a_r;
  logic [7:0]  bus_d_out_r;
  logic        bus_rw_r;

  logic        busy_nx_s;
  logic [15:0] bus_a_nx_s;
  logic [7:0]  bus_d_out_nx_s;
  logic        bus_rw_nx_s;

  // Next-state logic: trigger detection, alignment decision and copy loop
  always_comb begin
    state_nx_s = state_r;
    index_nx_s = index_r;
    page_nx_s  = page_r;
    latch_nx_s = latch_r;
    case (state_r)
      ST_IDLE: begin
        if ((cpu_a == TRIG_ADDR) && (cpu_rw == RW_W)) begin
          state_nx_s = ST_HALT;
          page_nx_s  = cpu_d;
          index_nx_s = 8'h00;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_HALT: begin
        state_nx_s = halt_exit(parity_r);
      end
      ST_ALIGN: begin
        state_nx_s = ST_READ;
      end
      ST_READ: begin
        latch_nx_s = bus_d_in;
        state_nx_s = ST_WRITE;
      end
      ST_WRITE: begin
        // index wraps back to 0 only on the final write
        index_nx_s = index_r + 8'd1;
        if (index_r == 8'hFF) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_READ;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so
  // that the output flops line up with the state register
  always_comb begin
    busy_nx_s      = 1'b0;
    bus_a_nx_s     = 16'h0000;
    bus_d_out_nx_s = 8'h00;
    bus_rw_nx_s    = RW_R;
    case (state_nx_s)
      ST_IDLE: begin
        busy_nx_s      = 1'b0;
        bus_a_nx_s     = 16'h0000;
        bus_d_out_nx_s = 8'h00;
        bus_rw_nx_s    = RW_R;
      end
      ST_HALT, ST_ALIGN: begin
        // dummy read of the page base; returned data is ignored
        busy_nx_s  = 1'b1;
        bus_a_nx_s = {page_nx_s, 8'h00};
      end
      ST_READ: begin
        busy_nx_s  = 1'b1;
        bus_a_nx_s = {page_nx_s, index_nx_s};
      end
      ST_WRITE: begin
        busy_nx_s      = 1'b1;
        bus_a_nx_s     = OAM_ADDR;
        bus_d_out_nx_s = latch_nx_s;
        bus_rw_nx_s    = RW_W;
      end
      default: begin
        busy_nx_s      = 1'b0;
        bus_a_nx_s     = 16'h0000;
        bus_d_out_nx_s = 8'h00;
        bus_rw_nx_s    = RW_R;
      end
    endcase
  end

  // State, datapath and cycle-parity registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      parity_r <= 1'b0;
      index_r  <= 8'h00;
      page_r   <= 8'h00;
      latch_r  <= 8'h00;
    end else begin
      state_r  <= state_nx_s;
      parity_r <= ~parity_r;
      index_r  <= index_nx_s;
      page_r   <= page_nx_s;
      latch_r  <= latch_nx_s;
    end
  end

  // Registered bus/handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      bus_a_r     <= 16'h0000;
      bus_d_out_r <= 8'h00;
      bus_rw_r    <= RW_R;
    end else begin
      busy_r      <= busy_nx_s;
      bus_a_r     <= bus_a_nx_s;
      bus_d_out_r <= bus_d_out_nx_s;
      bus_rw_r    <= bus_rw_nx_s;
    end
  end

  assign cpu_halt  = busy_r;
  assign bus_sel   = busy_r;
  assign dma_busy  = busy_r;
  assign bus_a     = bus_a_r;
  assign bus_d_out = bus_d_out_r;
  assign bus_rw    = bus_rw_r;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma.
// A 64 KiB memory array answers DMA reads. Single-edge trigger decoding is
// checked from a vector table; full transfers are checked against a
// reference built from the behavioural rules: halt length from the cycle
// parity, one or two dummy reads of the page base, then 256 reads of
// page:index each followed by a write of that byte to the OAM port.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_d = 8'h00;
  logic        cpu_rw = 1'b1;
  logic [7:0]  bus_d_in;
  logic        cpu_halt;
  logic        bus_sel;
  logic [15:0] bus_a;
  logic [7:0]  bus_d_out;
  logic        bus_rw;
  logic        dma_busy;

  logic [7:0]  mem [0:65535];

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;

  // observed transfer trace
  logic [15:0] rd_a [$];
  logic [15:0] wr_a [$];
  logic [7:0]  wr_d [$];
  int          halt_len;
  int          exp_len;

  oam_dma dut (
    .clk(clk), .rst_n(rst_n), .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_rw(cpu_rw),
    .bus_d_in(bus_d_in), .cpu_halt(cpu_halt), .bus_sel(bus_sel), .bus_a(bus_a),
    .bus_d_out(bus_d_out), .bus_rw(bus_rw), .dma_busy(dma_busy)
  );

  always #5 clk = ~clk;

  // count clock edges since reset release; the cycle after edge n has parity n%2
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  assign bus_d_in = mem[bus_a];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_halt"}, {31'd0, cpu_halt}, 32'd0);
    check({tag, "_sel"},  {31'd0, bus_sel},  32'd0);
    check({tag, "_busy"}, {31'd0, dma_busy}, 32'd0);
    check({tag, "_a"},    {16'd0, bus_a},    32'h0000);
    check({tag, "_dout"}, {24'd0, bus_d_out}, 32'h00);
    check({tag, "_rw"},   {31'd0, bus_rw},   32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_page_random(input logic [7:0] page);
    for (int i = 0; i < 256; i++) mem[{page, i[7:0]}] = 8'($urandom);
  endtask

  // Trigger a transfer from page; want_align selects the parity of the trigger
  // edge; inject_at > 0 re-writes $4014 with $07 during that halted cycle.
  task automatic run_transfer(input string tag, input logic [7:0] page,
                              input bit want_align, input int inject_at);
    int ndummy, bad, sig_bad, t, post_halts;
    rd_a.delete(); wr_a.delete(); wr_d.delete();
    halt_len = 0; sig_bad = 0;
    @(negedge clk);
    while (((((edge_cnt + 1) % 2) == 0) ? 1'b1 : 1'b0) != want_align) @(negedge clk);
    t = edge_cnt + 1;
    exp_len = ((t % 2) == 0) ? 514 : 513;
    cpu_a = 16'h4014; cpu_d = page; cpu_rw = 1'b0;
    @(posedge clk);
    #1;
    cpu_a = 16'h0000; cpu_d = 8'h00; cpu_rw = 1'b1;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (cpu_halt !== 1'b1) break;
      halt_len++;
      if (bus_sel !== 1'b1 || dma_busy !== 1'b1) sig_bad++;
      if (bus_rw === 1'b1) rd_a.push_back(bus_a);
      else begin wr_a.push_back(bus_a); wr_d.push_back(bus_d_out); end
      if (inject_at > 0 && halt_len == inject_at) begin
        cpu_a = 16'h4014; cpu_d = 8'h07; cpu_rw = 1'b0;
      end else begin
        cpu_a = 16'h0000; cpu_d = 8'h00; cpu_rw = 1'b1;
      end
    end
    cpu_a = 16'h0000; cpu_d = 8'h00; cpu_rw = 1'b1;
    check({tag, "_halt_len"}, halt_len, exp_len);
    check({tag, "_sel_busy"}, sig_bad, 0);
    check({tag, "_nwrites"}, wr_a.size(), 256);
    check({tag, "_nreads"}, rd_a.size(), exp_len - 256);
    if (rd_a.size() == exp_len - 256 && wr_a.size() == 256) begin
      ndummy = exp_len - 512;
      bad = 0;
      for (int i = 0; i < ndummy; i++) if (rd_a[i] !== {page, 8'h00}) bad++;
      check({tag, "_dummy_addr"}, bad, 0);
      bad = 0;
      for (int i = 0; i < 256; i++) if (rd_a[ndummy + i] !== ({page, 8'h00} + 16'(i))) bad++;
      check({tag, "_read_addr"}, bad, 0);
      bad = 0;
      for (int i = 0; i < 256; i++) if (wr_a[i] !== 16'h2004) bad++;
      check({tag, "_write_addr"}, bad, 0);
      bad = 0;
      for (int i = 0; i < 256; i++) if (wr_d[i] !== mem[{page, 8'h00} + 16'(i)]) bad++;
      check({tag, "_write_data"}, bad, 0);
    end
    check_idle_outputs({tag, "_end"});
    post_halts = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cpu_halt !== 1'b0) post_halts++;
    end
    check({tag, "_no_retrigger"}, post_halts, 0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw;
    logic        exp_halt;
    logic [15:0] exp_a;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic found;
    logic [7:0] pg;

    // ---- reset state ----
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ---- single-edge trigger decode table ----
    vecs[0] = '{a:16'h4014, d:8'h02, rw:1'b1, exp_halt:1'b0, exp_a:16'h0000};
    vecs[1] = '{a:16'h4015, d:8'h02, rw:1'b0, exp_halt:1'b0, exp_a:16'h0000};
    vecs[2] = '{a:16'h4013, d:8'h02, rw:1'b0, exp_halt:1'b0, exp_a:16'h0000};
    vecs[3] = '{a:16'h0014, d:8'h02, rw:1'b0, exp_halt:1'b0, exp_a:16'h0000};
    vecs[4] = '{a:16'h4014, d:8'h02, rw:1'b0, exp_halt:1'b1, exp_a:16'h0200};
    vecs[5] = '{a:16'hC014, d:8'h33, rw:1'b0, exp_halt:1'b0, exp_a:16'h0000};
    vecs[6] = '{a:16'h4014, d:8'hFF, rw:1'b0, exp_halt:1'b1, exp_a:16'hFF00};
    vecs[7] = '{a:16'h4014, d:8'h00, rw:1'b0, exp_halt:1'b1, exp_a:16'h0000};
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      cpu_a = vecs[v].a; cpu_d = vecs[v].d; cpu_rw = vecs[v].rw;
      @(negedge clk);
      cpu_a = 16'h0000; cpu_d = 8'h00; cpu_rw = 1'b1;
      check($sformatf("vec%0d_halt", v), {31'd0, cpu_halt}, {31'd0, vecs[v].exp_halt});
      check($sformatf("vec%0d_sel", v),  {31'd0, bus_sel},  {31'd0, vecs[v].exp_halt});
      check($sformatf("vec%0d_a", v),    {16'd0, bus_a},    {16'd0, vecs[v].exp_a});
      check($sformatf("vec%0d_rw", v),   {31'd0, bus_rw},   32'd1);
      if (vecs[v].exp_halt) do_reset();
    end

    // ---- scenario 1/2: page $02, both alignments ----
    fill_page_random(8'h02);
    run_transfer("even", 8'h02, 1'b0, 0);
    run_transfer("odd", 8'h02, 1'b1, 0);

    // ---- scenario 3: page $FF ----
    for (int i = 0; i < 256; i++) mem[16'hFF00 + 16'(i)] = 8'(i) ^ 8'hA5;
    run_transfer("pgff", 8'hFF, 1'($urandom_range(0, 1)), 0);
    check("pgff_last_read", {16'd0, (rd_a.size() > 0) ? rd_a[rd_a.size() - 1] : 16'h0000}, 32'hFFFF);
    check("pgff_last_data", {24'd0, (wr_d.size() > 0) ? wr_d[wr_d.size() - 1] : 8'h00}, 32'h5A);

    // ---- scenario 4: re-trigger while busy is ignored ----
    fill_page_random(8'h03);
    fill_page_random(8'h07);
    run_transfer("inject", 8'h03, 1'b0, 100);

    // ---- scenario 6: reset mid-transfer at index $40 ----
    fill_page_random(8'h05);
    @(negedge clk);
    cpu_a = 16'h4014; cpu_d = 8'h05; cpu_rw = 1'b0;
    @(posedge clk);
    #1;
    cpu_a = 16'h0000; cpu_d = 8'h00; cpu_rw = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus_rw === 1'b1 && bus_a === 16'h0540) begin found = 1'b1; break; end
    end
    check("mid_reached_40", {31'd0, found}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_halt", {31'd0, cpu_halt}, 32'd0);
    check("mid_rst_sel",  {31'd0, bus_sel},  32'd0);
    check("mid_rst_busy", {31'd0, dma_busy}, 32'd0);
    check("mid_rst_a",    {16'd0, bus_a},    32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    run_transfer("after_rst", 8'h05, 1'($urandom_range(0, 1)), 0);

    // ---- randomized transfers ----
    for (int r = 0; r < 4; r++) begin
      pg = 8'($urandom);
      fill_page_random(pg);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_transfer($sformatf("rand%0d", r), pg, 1'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
